// File: rtl/jk_onoff_bank.sv
// jk_onoff_bank
//   Bank of CH independent ON/OFF channels. Each channel is a two-state JK
//   machine with a selectable j=k=1 policy and an ON-time watchdog. A global
//   enable freezes all state. A live popcount of ON channels is also provided.
//
// Ports
//   clk      : system clock, all state updates on the rising edge
//   reset    : synchronous active-high reset, priority over en
//   en       : global enable; when low, state and counters hold
//   mode     : j=k=1 policy, 0 = toggle, 1 = OFF-priority (k wins)
//   j        : per-channel set request
//   k        : per-channel clear request
//   out      : registered channel state (1 = ON)
//   timeout  : registered one-cycle pulse, channel forced OFF by watchdog
//   on_num   : combinational count of ON channels
//
// Parameters
//   CH       : number of channels (1..32)
//   CNT_W    : ON-time counter width, 2^CNT_W >= TIMEOUT
//   TIMEOUT  : max consecutive enabled ON cycles, 0 disables the watchdog

module jk_onoff_bank #(
  parameter int CH      = 4,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 100
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      mode,
  input  logic [CH-1:0]             j,
  input  logic [CH-1:0]             k,
  output logic [CH-1:0]             out,
  output logic [CH-1:0]             timeout,
  output logic [$clog2(CH+1)-1:0]   on_num
);

  localparam int NUM_W = $clog2(CH + 1);
  localparam bit WD_ON = (TIMEOUT > 0);
  // Terminal count is TIMEOUT-1 because the counter starts at 0 on entry,
  // which gives exactly TIMEOUT enabled cycles of ON.
  localparam logic [CNT_W-1:0] TERM = WD_ON ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic {
    OFF = 1'b0,
    ON  = 1'b1
  } ch_state_t;

  ch_state_t        state_q [CH];
  ch_state_t        state_d [CH];
  logic [CNT_W-1:0] cnt_q   [CH];
  logic [CNT_W-1:0] cnt_d   [CH];
  logic [CH-1:0]    to_d;

  // Next-state logic for every channel. The watchdog is checked before k so
  // a coincident clear still reports the timeout and yields a single OFF.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      to_d[i]    = 1'b0;
      if (en) begin
        case (state_q[i])
          OFF: begin
            if (j[i] && !(mode && k[i])) begin
              state_d[i] = ON;
              cnt_d[i]   = '0;
            end
          end
          ON: begin
            if (WD_ON && (cnt_q[i] == TERM)) begin
              state_d[i] = OFF;
              cnt_d[i]   = '0;
              to_d[i]    = 1'b1;
            end else if (k[i]) begin
              state_d[i] = OFF;
              cnt_d[i]   = '0;
            end else if (WD_ON) begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
          default: begin
            state_d[i] = OFF;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  // State register. With en low the next-state logic already holds state
  // and counters, and timeout falls to 0 because to_d defaults low.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= OFF;
        cnt_q[i]   <= '0;
      end
      timeout <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      timeout <= to_d;
    end
  end

  // Channel state flattened onto the output vector.
  always_comb begin
    out = '0;
    for (int i = 0; i < CH; i++) begin
      out[i] = (state_q[i] == ON);
    end
  end

  // Popcount of the registered outputs, no added latency.
  always_comb begin
    on_num = '0;
    for (int i = 0; i < CH; i++) begin
      on_num = on_num + NUM_W'(out[i]);
    end
  end

endmodule

// File: tb/tb_jk_onoff_bank.sv
// tb_jk_onoff_bank
//   Bench for jk_onoff_bank with CH=4, CNT_W=8, TIMEOUT=5, plus a second
//   instance with TIMEOUT=0 sharing the same inputs for the disabled-watchdog
//   case. Each driven cycle pushes the expected post-edge outputs from a
//   behavioural model onto a queue; tasks pop and compare after the edge,
//   and also check literal values at the key points of each scenario.

module tb_jk_onoff_bank;

  localparam int TO_P = 5;

  logic       clk;
  logic       reset;
  logic       en;
  logic       mode;
  logic [3:0] j;
  logic [3:0] k;
  logic [3:0] out;
  logic [3:0] timeout;
  logic [2:0] on_num;
  logic [3:0] out0;
  logic [3:0] timeout0;
  logic [2:0] on_num0;

  int vectors;
  int miscompares;

  typedef struct {
    logic [3:0] out;
    logic [3:0] to;
    logic [2:0] num;
  } exp_t;

  exp_t sb[$];
  exp_t exp_e;

  // Behavioural model: m_age counts ON cycles elapsed, 1 on entry.
  logic [3:0] m_out;
  logic [3:0] m_to;
  int         m_age [4];

  jk_onoff_bank #(.CH(4), .CNT_W(8), .TIMEOUT(TO_P)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .j(j), .k(k),
    .out(out), .timeout(timeout), .on_num(on_num)
  );

  jk_onoff_bank #(.CH(4), .CNT_W(8), .TIMEOUT(0)) dut0 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .j(j), .k(k),
    .out(out0), .timeout(timeout0), .on_num(on_num0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle at the falling edge, advance the model, push the
  // expectation, then return 1 time unit after the next rising edge.
  task automatic drive_cycle(input logic r, input logic e, input logic m,
                             input logic [3:0] jj, input logic [3:0] kk);
    exp_t x;
    @(negedge clk);
    reset = r; en = e; mode = m; j = jj; k = kk;
    if (r) begin
      m_out = '0;
      m_to  = '0;
      for (int i = 0; i < 4; i++) m_age[i] = 0;
    end else if (!e) begin
      m_to = '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        m_to[i] = 1'b0;
        if (m_out[i]) begin
          if (m_age[i] == TO_P) begin
            m_out[i] = 1'b0; m_to[i] = 1'b1; m_age[i] = 0;
          end else if (kk[i]) begin
            m_out[i] = 1'b0; m_age[i] = 0;
          end else begin
            m_age[i] = m_age[i] + 1;
          end
        end else if (jj[i] && !(m && kk[i])) begin
          m_out[i] = 1'b1; m_age[i] = 1;
        end
      end
    end
    x.out = m_out;
    x.to  = m_to;
    x.num = 3'($countones(m_out));
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int n = 0; n < 12; n++) begin
      if (n < 2) drive_cycle(1'b1, 1'b1, 1'b0, 4'hF, 4'h0);
      else       drive_cycle(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
      exp_e = sb.pop_front();
      vectors++;
      if (out !== exp_e.out || timeout !== exp_e.to || on_num !== exp_e.num) begin
        miscompares++;
        $display("[TB] FAIL sb_reset n=%0d got out=%b to=%b num=%0d want out=%b to=%b num=%0d",
                 n, out, timeout, on_num, exp_e.out, exp_e.to, exp_e.num);
      end
      vectors++;
      if (out !== 4'h0 || timeout !== 4'h0 || on_num !== 3'd0) begin
        miscompares++;
        $display("[TB] FAIL reset_idle n=%0d got out=%b to=%b num=%0d want 0000/0000/0",
                 n, out, timeout, on_num);
      end
    end
  endtask

  task automatic test_basic_jk();
    logic [3:0] js   [4] = '{4'b0011, 4'b0001, 4'b0001, 4'b0000};
    logic [3:0] ks   [4] = '{4'b0000, 4'b0001, 4'b0001, 4'b1111};
    logic [3:0] want [4] = '{4'b0011, 4'b0010, 4'b0011, 4'b0000};
    logic [2:0] wnum [4] = '{3'd2, 3'd1, 3'd2, 3'd0};
    for (int n = 0; n < 4; n++) begin
      drive_cycle(1'b0, 1'b1, 1'b0, js[n], ks[n]);
      exp_e = sb.pop_front();
      vectors++;
      if (out !== exp_e.out || timeout !== exp_e.to || on_num !== exp_e.num) begin
        miscompares++;
        $display("[TB] FAIL sb_basic n=%0d got out=%b to=%b num=%0d want out=%b to=%b num=%0d",
                 n, out, timeout, on_num, exp_e.out, exp_e.to, exp_e.num);
      end
      vectors++;
      if (out !== want[n] || on_num !== wnum[n]) begin
        miscompares++;
        $display("[TB] FAIL basic_jk n=%0d got out=%b num=%0d want out=%b num=%0d",
                 n, out, on_num, want[n], wnum[n]);
      end
    end
  endtask

  task automatic test_mode_priority();
    logic [3:0] js   [3] = '{4'b1000, 4'b1000, 4'b1000};
    logic [3:0] ks   [3] = '{4'b1000, 4'b0000, 4'b1000};
    logic [3:0] want [3] = '{4'b0000, 4'b1000, 4'b0000};
    for (int n = 0; n < 3; n++) begin
      drive_cycle(1'b0, 1'b1, 1'b1, js[n], ks[n]);
      exp_e = sb.pop_front();
      vectors++;
      if (out !== exp_e.out || timeout !== exp_e.to || on_num !== exp_e.num) begin
        miscompares++;
        $display("[TB] FAIL sb_mode n=%0d got out=%b to=%b num=%0d want out=%b to=%b num=%0d",
                 n, out, timeout, on_num, exp_e.out, exp_e.to, exp_e.num);
      end
      vectors++;
      if (out !== want[n]) begin
        miscompares++;
        $display("[TB] FAIL mode_priority n=%0d got out=%b want out=%b", n, out, want[n]);
      end
    end
  endtask

  task automatic test_watchdog();
    logic [3:0] w_out;
    logic [3:0] w_to;
    // 7 cycles after a single j pulse, then 12 cycles with j held high.
    for (int n = 0; n < 19; n++) begin
      int p;
      if (n < 7) begin
        drive_cycle(1'b0, 1'b1, 1'b0, (n == 0) ? 4'b0001 : 4'b0000, 4'b0000);
        p = n;
      end else begin
        drive_cycle(1'b0, 1'b1, 1'b0, 4'b0001, 4'b0000);
        p = (n - 7) % 6;
      end
      w_out = (p < TO_P)  ? 4'b0001 : 4'b0000;
      w_to  = (p == TO_P) ? 4'b0001 : 4'b0000;
      exp_e = sb.pop_front();
      vectors++;
      if (out !== exp_e.out || timeout !== exp_e.to || on_num !== exp_e.num) begin
        miscompares++;
        $display("[TB] FAIL sb_watchdog n=%0d got out=%b to=%b num=%0d want out=%b to=%b num=%0d",
                 n, out, timeout, on_num, exp_e.out, exp_e.to, exp_e.num);
      end
      vectors++;
      if (out !== w_out || timeout !== w_to || on_num !== 3'($countones(w_out))) begin
        miscompares++;
        $display("[TB] FAIL watchdog n=%0d got out=%b to=%b num=%0d want out=%b to=%b",
                 n, out, timeout, on_num, w_out, w_to);
      end
    end
    drive_cycle(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000);
    void'(sb.pop_front());
  endtask

  task automatic test_en_gating();
    logic [3:0] w_out;
    logic [3:0] w_to;
    // 3 enabled cycles to reach on_cnt=2, 7 frozen, 4 enabled.
    for (int n = 0; n < 14; n++) begin
      if (n == 0)      drive_cycle(1'b0, 1'b1, 1'b0, 4'b0010, 4'b0000);
      else if (n < 3)  drive_cycle(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000);
      else if (n < 10) drive_cycle(1'b0, 1'b0, n[0], n[0] ? 4'hF : 4'h0, n[0] ? 4'hA : 4'h5);
      else             drive_cycle(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000);
      w_out = (n < 12) ? 4'b0010 : 4'b0000;
      w_to  = (n == 12) ? 4'b0010 : 4'b0000;
      exp_e = sb.pop_front();
      vectors++;
      if (out !== exp_e.out || timeout !== exp_e.to || on_num !== exp_e.num) begin
        miscompares++;
        $display("[TB] FAIL sb_en n=%0d got out=%b to=%b num=%0d want out=%b to=%b num=%0d",
                 n, out, timeout, on_num, exp_e.out, exp_e.to, exp_e.num);
      end
      vectors++;
      if (out !== w_out || timeout !== w_to) begin
        miscompares++;
        $display("[TB] FAIL en_gating n=%0d got out=%b to=%b want out=%b to=%b",
                 n, out, timeout, w_out, w_to);
      end
    end
  endtask

  task automatic test_corner();
    // k on the terminal-count edge, then reset on the terminal-count edge.
    for (int pass = 0; pass < 2; pass++) begin
      for (int n = 0; n < 7; n++) begin
        logic [3:0] w_out;
        logic [3:0] w_to;
        if (n == 0)      drive_cycle(1'b0, 1'b1, 1'b0, 4'b0100, 4'b0000);
        else if (n < 5)  drive_cycle(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000);
        else if (n == 5) drive_cycle(pass == 1, 1'b1, 1'b0, 4'b0000,
                                     (pass == 0) ? 4'b0100 : 4'b0000);
        else             drive_cycle(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000);
        w_out = (n < 5) ? 4'b0100 : 4'b0000;
        w_to  = (n == 5 && pass == 0) ? 4'b0100 : 4'b0000;
        exp_e = sb.pop_front();
        vectors++;
        if (out !== exp_e.out || timeout !== exp_e.to || on_num !== exp_e.num) begin
          miscompares++;
          $display("[TB] FAIL sb_corner p=%0d n=%0d got out=%b to=%b num=%0d want out=%b to=%b num=%0d",
                   pass, n, out, timeout, on_num, exp_e.out, exp_e.to, exp_e.num);
        end
        vectors++;
        if (out !== w_out || timeout !== w_to) begin
          miscompares++;
          $display("[TB] FAIL corner p=%0d n=%0d got out=%b to=%b want out=%b to=%b",
                   pass, n, out, timeout, w_out, w_to);
        end
      end
    end
  endtask

  task automatic test_no_watchdog();
    drive_cycle(1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000);
    void'(sb.pop_front());
    for (int n = 0; n < 200; n++) begin
      drive_cycle(1'b0, 1'b1, 1'b0, (n == 0) ? 4'b0001 : 4'b0000, 4'b0000);
      exp_e = sb.pop_front();
      vectors++;
      if (out !== exp_e.out || timeout !== exp_e.to || on_num !== exp_e.num) begin
        miscompares++;
        $display("[TB] FAIL sb_nowd n=%0d got out=%b to=%b num=%0d want out=%b to=%b num=%0d",
                 n, out, timeout, on_num, exp_e.out, exp_e.to, exp_e.num);
      end
      vectors++;
      if (out0 !== 4'b0001 || timeout0 !== 4'b0000 || on_num0 !== 3'd1) begin
        miscompares++;
        $display("[TB] FAIL no_watchdog n=%0d got out=%b to=%b num=%0d want 0001/0000/1",
                 n, out0, timeout0, on_num0);
      end
    end
  endtask

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL time_limit expired at %0t, limit 200000", $time);
    $fatal(1, "[TB] time limit");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset = 1'b1; en = 1'b0; mode = 1'b0; j = '0; k = '0;
    m_out = '0; m_to = '0;
    for (int i = 0; i < 4; i++) m_age[i] = 0;
    test_reset();
    test_basic_jk();
    test_mode_priority();
    test_watchdog();
    test_en_gating();
    test_corner();
    test_no_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
